// File: rtl/uart_pkg.sv
// Shared types and constants for the duplex UART.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int PAR_ERR = 0;
    localparam int FRM_ERR = 1;

    localparam logic [15:0] MIN_BAUD_DIV = 16'd4;

    function automatic logic [15:0] eff_div(
        input logic [15:0] d
    );
        return (d < MIN_BAUD_DIV) ? MIN_BAUD_DIV : d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/level.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Empty reads as zero so the head is defined out of reset.
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_duplex_fifo.sv
// Full-duplex UART: TX/RX engines with FIFOs,
// runtime baud divisor, parity and loopback.
module uart_duplex_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       baud_div,
    input  logic [1:0]        parity_type,
    input  logic              loopback,
    input  logic              ovf_clr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic [1:0]        rx_err,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              rx_serial,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              rx_busy,
    output logic              rx_overflow,
    output logic [LVL_W-1:0]  tx_level,
    output logic [LVL_W-1:0]  rx_level
);

    localparam int BCW = $clog2(DATA_W + 1);
    localparam int RW  = DATA_W + 2;

    logic [15:0] cfg_div;
    parity_e     cfg_par;
    logic        cfg_par_en;
    logic        cfg_par_odd;

    assign cfg_div     = eff_div(baud_div);
    assign cfg_par     = parity_e'(parity_type);
    assign cfg_par_en  = (cfg_par == PAR_ODD) ||
                         (cfg_par == PAR_EVEN);
    assign cfg_par_odd = (cfg_par == PAR_ODD);

    // ---------------- TX ----------------
    tx_state_e         tx_state, tx_state_n;
    logic [15:0]       tx_div, tx_div_n;
    logic [15:0]       tx_cnt, tx_cnt_n;
    logic [BCW-1:0]    tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shr, tx_shr_n;
    logic              tx_par_en, tx_par_en_n;
    logic              tx_par_bit, tx_par_bit_n;
    logic              tx_line, tx_line_n;
    logic              tx_tick;
    logic              tx_load;
    logic [DATA_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (tx_load),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    assign tx_ready  = !tx_full;
    assign tx_busy   = (tx_state != TX_IDLE);
    assign tx_tick   = (tx_cnt == 16'd0);
    assign tx_serial = loopback ? 1'b1 : tx_line;

    always_comb begin
        tx_state_n   = tx_state;
        tx_div_n     = tx_div;
        tx_cnt_n     = tx_cnt;
        tx_bit_n     = tx_bit;
        tx_shr_n     = tx_shr;
        tx_par_en_n  = tx_par_en;
        tx_par_bit_n = tx_par_bit;
        tx_load      = 1'b0;
        tx_line_n    = 1'b1;
        unique case (tx_state)
            TX_IDLE: tx_load = !tx_empty;
            TX_START: begin
                if (tx_tick) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shr_n = tx_shr >> 1;
                    if (tx_bit == BCW'(DATA_W - 1)) begin
                        tx_state_n = tx_par_en ? TX_PARITY
                                               : TX_STOP;
                        tx_bit_n   = '0;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_bit == BCW'(STOP_BITS - 1)) begin
                        tx_state_n = TX_IDLE;
                        tx_load    = !tx_empty;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_state != TX_IDLE)
            tx_cnt_n = tx_tick ? tx_div - 16'd1
                               : tx_cnt - 16'd1;
        // Loading from STOP chains frames with no idle gap.
        if (tx_load) begin
            tx_state_n   = TX_START;
            tx_div_n     = cfg_div;
            tx_cnt_n     = cfg_div - 16'd1;
            tx_shr_n     = tx_head;
            tx_bit_n     = '0;
            tx_par_en_n  = cfg_par_en;
            tx_par_bit_n = (^tx_head) ^ cfg_par_odd;
        end
        unique case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shr_n[0];
            TX_PARITY: tx_line_n = tx_par_bit_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_div     <= MIN_BAUD_DIV;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shr     <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_line    <= 1'b1;
        end else begin
            tx_state   <= tx_state_n;
            tx_div     <= tx_div_n;
            tx_cnt     <= tx_cnt_n;
            tx_bit     <= tx_bit_n;
            tx_shr     <= tx_shr_n;
            tx_par_en  <= tx_par_en_n;
            tx_par_bit <= tx_par_bit_n;
            tx_line    <= tx_line_n;
        end
    end

    // ---------------- RX ----------------
    rx_state_e         rx_state, rx_state_n;
    logic [15:0]       rx_div, rx_div_n;
    logic [15:0]       rx_cnt, rx_cnt_n;
    logic [BCW-1:0]    rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shr, rx_shr_n;
    logic              rx_par_en, rx_par_en_n;
    logic              rx_par_odd, rx_par_odd_n;
    logic              rx_perr, rx_perr_n;
    logic              rx_hold, rx_hold_n;
    logic              rx_s1, rx_s2, rx_prev;
    logic              rx_fall;
    logic              rx_tick;
    logic              rx_push;
    logic [1:0]        rx_werr;
    logic [RW-1:0]     rx_head;
    logic              rx_full;
    logic              rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= loopback ? tx_line : rx_serial;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_tick = (rx_cnt == 16'd0);
    assign rx_busy = (rx_state != RX_IDLE);

    always_comb begin
        rx_state_n   = rx_state;
        rx_div_n     = rx_div;
        rx_cnt_n     = rx_cnt;
        rx_bit_n     = rx_bit;
        rx_shr_n     = rx_shr;
        rx_par_en_n  = rx_par_en;
        rx_par_odd_n = rx_par_odd;
        rx_perr_n    = rx_perr;
        rx_hold_n    = rx_hold;
        rx_push      = 1'b0;
        rx_werr      = 2'b00;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_hold && rx_s2) rx_hold_n = 1'b0;
                if (!rx_hold && rx_fall) begin
                    rx_state_n   = RX_START;
                    rx_div_n     = cfg_div;
                    rx_cnt_n     = (cfg_div >> 1) - 16'd1;
                    rx_par_en_n  = cfg_par_en;
                    rx_par_odd_n = cfg_par_odd;
                    rx_perr_n    = 1'b0;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    rx_bit_n   = '0;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shr_n = {rx_s2, rx_shr[DATA_W-1:1]};
                    if (rx_bit == BCW'(DATA_W - 1))
                        rx_state_n = rx_par_en ? RX_PARITY
                                               : RX_STOP;
                    else
                        rx_bit_n = rx_bit + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_perr_n  = (^{rx_shr, rx_s2}) ^ rx_par_odd;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                // Push mid stop bit so the next start edge is caught.
                if (rx_tick) begin
                    rx_push          = 1'b1;
                    rx_werr[PAR_ERR] = rx_perr;
                    rx_werr[FRM_ERR] = !rx_s2;
                    rx_hold_n        = !rx_s2;
                    rx_state_n       = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (rx_state != RX_IDLE)
            rx_cnt_n = rx_tick ? rx_div - 16'd1
                               : rx_cnt - 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_div     <= MIN_BAUD_DIV;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shr     <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_perr    <= 1'b0;
            rx_hold    <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_div     <= rx_div_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shr     <= rx_shr_n;
            rx_par_en  <= rx_par_en_n;
            rx_par_odd <= rx_par_odd_n;
            rx_perr    <= rx_perr_n;
            rx_hold    <= rx_hold_n;
        end
    end

    uart_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata ({rx_werr, rx_shr_n}),
        .pop   (rx_ready),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign rx_valid = !rx_empty;
    assign rx_data  = rx_head[DATA_W-1:0];
    assign rx_err   = rx_head[DATA_W +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_overflow <= 1'b0;
        else if (rx_push && rx_full)
            rx_overflow <= 1'b1;
        else if (ovf_clr)
            rx_overflow <= 1'b0;
    end

endmodule
